// File: rtl/fwrisc_alu_pkg.sv
// fwrisc_alu_pkg
// Shared opcode encoding for fwrisc_alu. Any block that drives the ALU takes
// its OP_* values from here so the encoding lives in exactly one place.
// No ports (package).
package fwrisc_alu_pkg;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_CLR = 4'd4;   // op_b & ~op_a
    localparam logic [3:0] OP_EQ  = 4'd5;
    localparam logic [3:0] OP_NE  = 4'd6;
    localparam logic [3:0] OP_LT  = 4'd7;
    localparam logic [3:0] OP_GE  = 4'd8;
    localparam logic [3:0] OP_LTU = 4'd9;
    localparam logic [3:0] OP_GEU = 4'd10;
    localparam logic [3:0] OP_OPA = 4'd11;  // pass op_a
    localparam logic [3:0] OP_OPB = 4'd12;  // pass op_b
    localparam logic [3:0] OP_XOR = 4'd13;

endpackage

// File: rtl/fwrisc_csr_pkg.sv
// fwrisc_csr_pkg
// Types and constants for the CSR read-modify-write sequencer:
//   csr_kind_e   - request kind (RW/RS/RC, 11 is reserved and handled as RS)
//   csr_state_e  - sequencer FSM state
//   CSR_RO_FIELD - value of addr[11:10] marking the read-only CSR space
// No ports (package).
package fwrisc_csr_pkg;

    typedef enum logic [1:0] {
        CSR_RW  = 2'b00,
        CSR_RS  = 2'b01,
        CSR_RC  = 2'b10,
        CSR_RSV = 2'b11
    } csr_kind_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_EXE  = 3'd2,
        ST_WR   = 3'd3,
        ST_RSP  = 3'd4
    } csr_state_e;

    localparam logic [1:0] CSR_RO_FIELD = 2'b11;

endpackage

// File: rtl/fwrisc_csr_rmw_seq.sv
// fwrisc_csr_rmw_seq
// Multi-cycle sequencer for CSRRW/CSRRS/CSRRC (and immediate forms).
// Reads the CSR, borrows the shared ALU for one cycle to form the new value,
// writes it back and returns the old value for rd.
//   IDLE -> RD -> EXE -> (WR) -> RSP -> IDLE
//
// Ports:
//   clock, reset        clock, synchronous active-high reset
//   req_*               request channel (kind, addr, src, src_zero, rd_zero)
//   csr_re/raddr/rdata  CSR read port, rdata valid the cycle after csr_re
//   csr_we/waddr/wdata  CSR write port
//   alu_own, alu_op_a/b, alu_op, alu_out   shared ALU port (owned in EXE only)
//   rsp_*               response channel (old value, rd write enable)
//   rsp_err             only with FWRISC_CSR_RO_CHECK_EN: write to read-only CSR
//   dbg_state           current FSM state
//
// Handshakes: a transfer happens on a clock edge where valid && ready are both
// 1. Valid, once raised, is held with its payload stable until that edge;
// ready may change freely and never depends combinationally on valid.
// req_ready is 1 only in IDLE; rsp_valid is 1 only in RSP.
//
// Optional macro FWRISC_CSR_RO_CHECK_EN: adds rsp_err and suppresses writes to
// the read-only CSR space (addr[11:10]==2'b11).
module fwrisc_csr_rmw_seq
    import fwrisc_alu_pkg::*;
    import fwrisc_csr_pkg::*;
#(
    parameter int CSR_ADDR_W = 12,
    parameter int DATA_W     = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [1:0]            req_kind,
    input  logic [CSR_ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0]     req_src,
    input  logic                  req_src_zero,
    input  logic                  req_rd_zero,
    output logic                  csr_re,
    output logic [CSR_ADDR_W-1:0] csr_raddr,
    input  logic [DATA_W-1:0]     csr_rdata,
    output logic                  csr_we,
    output logic [CSR_ADDR_W-1:0] csr_waddr,
    output logic [DATA_W-1:0]     csr_wdata,
    output logic                  alu_own,
    output logic [DATA_W-1:0]     alu_op_a,
    output logic [DATA_W-1:0]     alu_op_b,
    output logic [3:0]            alu_op,
    input  logic [DATA_W-1:0]     alu_out,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_rd_we,
`ifdef FWRISC_CSR_RO_CHECK_EN
    output logic                  rsp_err,
`endif
    output csr_state_e            dbg_state
);

    csr_state_e            state;
    csr_kind_e             kind_q;
    logic [CSR_ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0]     src_q;
    logic [DATA_W-1:0]     old_q;
    logic [DATA_W-1:0]     wdata_q;
    logic                  rd_en_q;
    logic                  rd_we_q;
    logic                  wr_go_q;   // a CSR write will actually be issued
    logic                  ro_q;      // write targeted read-only space

    // Request decode, evaluated on the accept cycle only.
    logic req_wr_en;
    logic req_rd_en;
    logic req_ro;

    always_comb begin
        req_wr_en = (req_kind == CSR_RW) || !req_src_zero;
        // CSRRW to x0 must not cause read side effects.
        req_rd_en = !((req_kind == CSR_RW) && req_rd_zero);
`ifdef FWRISC_CSR_RO_CHECK_EN
        req_ro = req_wr_en && (req_addr[CSR_ADDR_W-1 -: 2] == CSR_RO_FIELD);
`else
        req_ro = 1'b0;
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= ST_IDLE;
            kind_q  <= CSR_RW;
            addr_q  <= '0;
            src_q   <= '0;
            old_q   <= '0;
            wdata_q <= '0;
            rd_en_q <= 1'b0;
            rd_we_q <= 1'b0;
            wr_go_q <= 1'b0;
            ro_q    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        kind_q  <= csr_kind_e'(req_kind);
                        addr_q  <= req_addr;
                        src_q   <= req_src;
                        rd_en_q <= req_rd_en;
                        rd_we_q <= !req_rd_zero;
                        wr_go_q <= req_wr_en && !req_ro;
                        ro_q    <= req_ro;
                        state   <= ST_RD;
                    end
                end
                ST_RD: state <= ST_EXE;
                ST_EXE: begin
                    old_q   <= rd_en_q ? csr_rdata : '0;
                    wdata_q <= alu_out;
                    state   <= wr_go_q ? ST_WR : ST_RSP;
                end
                ST_WR: state <= ST_RSP;
                ST_RSP: begin
                    if (rsp_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Outputs are decoded from the state register only; data outputs are
    // zero outside the phase that qualifies them.
    always_comb begin
        req_ready = (state == ST_IDLE);
        csr_re    = (state == ST_RD) && rd_en_q;
        csr_raddr = (state == ST_RD) ? addr_q : '0;
        // Gated by reset so an abort in the WR cycle never reaches the CSR file.
        csr_we    = (state == ST_WR) && !reset;
        csr_waddr = (state == ST_WR) ? addr_q : '0;
        csr_wdata = (state == ST_WR) ? wdata_q : '0;
        rsp_valid = (state == ST_RSP);
        rsp_rdata = (state == ST_RSP) ? old_q : '0;
        rsp_rd_we = (state == ST_RSP) && rd_we_q && !ro_q;
`ifdef FWRISC_CSR_RO_CHECK_EN
        rsp_err   = (state == ST_RSP) && ro_q;
`endif
        dbg_state = state;
    end

    // ALU port: csr_rdata arrives in EXE, so operands are passed straight
    // through in that cycle rather than registered.
    always_comb begin
        alu_own  = 1'b0;
        alu_op_a = '0;
        alu_op_b = '0;
        alu_op   = '0;
        if (state == ST_EXE) begin
            alu_own  = 1'b1;
            alu_op_a = src_q;
            alu_op_b = rd_en_q ? csr_rdata : '0;
            case (kind_q)
                CSR_RW:  alu_op = OP_OPA;
                CSR_RC:  alu_op = OP_CLR;
                default: alu_op = OP_OR;
            endcase
        end
    end

endmodule

// File: tb/tb_fwrisc_csr_rmw_seq.sv
// tb_fwrisc_csr_rmw_seq
// Bench for fwrisc_csr_rmw_seq: CSR file and ALU stand-ins, a cycle-timeline
// reference model checked every cycle, and directed requests with literal
// expectations.
module tb_fwrisc_csr_rmw_seq;
    import fwrisc_alu_pkg::*;
    import fwrisc_csr_pkg::*;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    // ---------------- DUT signals ----------------
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_kind = 2'b00;
    logic [11:0] req_addr = '0;
    logic [31:0] req_src = '0;
    logic        req_src_zero = 1'b0;
    logic        req_rd_zero = 1'b0;
    logic        csr_re;
    logic [11:0] csr_raddr;
    logic [31:0] csr_rdata = 32'hA5A5_5A5A;
    logic        csr_we;
    logic [11:0] csr_waddr;
    logic [31:0] csr_wdata;
    logic        alu_own;
    logic [31:0] alu_op_a;
    logic [31:0] alu_op_b;
    logic [3:0]  alu_op;
    logic [31:0] alu_out;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_rdata;
    logic        rsp_rd_we;
    logic        rsp_err_s;
    csr_state_e  dbg_state;

    fwrisc_csr_rmw_seq #(.CSR_ADDR_W(12), .DATA_W(32)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_kind(req_kind),
        .req_addr(req_addr), .req_src(req_src), .req_src_zero(req_src_zero),
        .req_rd_zero(req_rd_zero),
        .csr_re(csr_re), .csr_raddr(csr_raddr), .csr_rdata(csr_rdata),
        .csr_we(csr_we), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
        .alu_own(alu_own), .alu_op_a(alu_op_a), .alu_op_b(alu_op_b),
        .alu_op(alu_op), .alu_out(alu_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_rd_we(rsp_rd_we),
`ifdef FWRISC_CSR_RO_CHECK_EN
        .rsp_err(rsp_err_s),
`endif
        .dbg_state(dbg_state)
    );

`ifndef FWRISC_CSR_RO_CHECK_EN
    assign rsp_err_s = 1'b0;
`endif

    // ---------------- scoreboard bookkeeping ----------------
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // ---------------- ALU stand-in ----------------
    always_comb begin
        case (alu_op)
            OP_OPA:  alu_out = alu_op_a;
            OP_OR:   alu_out = alu_op_a | alu_op_b;
            OP_CLR:  alu_out = alu_op_b & ~alu_op_a;
            default: alu_out = 32'h0;
        endcase
    end

    // ---------------- CSR file stand-in ----------------
    logic [31:0] mem [logic [11:0]];
    logic        re_pend = 1'b0;
    logic [11:0] re_addr = '0;

    function automatic logic [31:0] mem_rd(input logic [11:0] a);
        return mem.exists(a) ? mem[a] : 32'h0;
    endfunction

    always @(negedge clock) begin
        re_pend = csr_re;
        re_addr = csr_raddr;
        if (csr_we) mem[csr_waddr] = csr_wdata;
    end

    // Read data appears the cycle after csr_re; junk otherwise so that any
    // use of unread data shows up.
    always @(posedge clock) begin
        #1;
        csr_rdata = re_pend ? mem_rd(re_addr) : 32'hA5A5_5A5A;
    end

    // ---------------- reference model (cycle timeline) ----------------
    // Cycle 0 is the accept cycle; the read strobe is cycle 1, the ALU cycle
    // 2, the write (if any) cycle 3, and the response from cycle 3 or 4 until
    // the handshake.
    bit          m_active = 1'b0;
    int          m_t = 0;
    int          m_rsp_t = 0;
    logic [11:0] m_addr;
    logic [31:0] m_src, m_old, m_new;
    logic [3:0]  m_op;
    bit          m_rd, m_wr, m_ro, m_wr_issue, m_rd_zero;

    always @(negedge clock) begin
        if (reset) begin
            chk("csr_we_in_reset", csr_we, 0);
            m_active = 1'b0;
        end else if (!m_active) begin
            chk("idle_req_ready", req_ready, 1);
            chk("idle_csr_re", csr_re, 0);
            chk("idle_csr_raddr", csr_raddr, 0);
            chk("idle_csr_we", csr_we, 0);
            chk("idle_csr_waddr", csr_waddr, 0);
            chk("idle_csr_wdata", csr_wdata, 0);
            chk("idle_alu_own", alu_own, 0);
            chk("idle_alu_op_a", alu_op_a, 0);
            chk("idle_alu_op_b", alu_op_b, 0);
            chk("idle_alu_op", alu_op, 0);
            chk("idle_rsp_valid", rsp_valid, 0);
            chk("idle_rsp_rdata", rsp_rdata, 0);
            chk("idle_rsp_rd_we", rsp_rd_we, 0);
            chk("idle_rsp_err", rsp_err_s, 0);
            if (req_valid) begin
                m_addr    = req_addr;
                m_src     = req_src;
                m_rd_zero = req_rd_zero;
                m_wr      = (req_kind == 2'b00) || !req_src_zero;
                m_rd      = !((req_kind == 2'b00) && req_rd_zero);
`ifdef FWRISC_CSR_RO_CHECK_EN
                m_ro      = m_wr && (req_addr[11:10] == 2'b11);
`else
                m_ro      = 1'b0;
`endif
                m_wr_issue = m_wr && !m_ro;
                m_old     = m_rd ? mem_rd(req_addr) : 32'h0;
                case (req_kind)
                    2'b00: begin m_new = req_src;           m_op = OP_OPA; end
                    2'b10: begin m_new = m_old & ~req_src;  m_op = OP_CLR; end
                    default: begin m_new = m_old | req_src; m_op = OP_OR;  end
                endcase
                m_rsp_t  = m_wr_issue ? 4 : 3;
                m_t      = 1;
                m_active = 1'b1;
            end
        end else begin
            chk("req_ready", req_ready, 0);
            chk("csr_re", csr_re, (m_t == 1) && m_rd);
            chk("csr_raddr", csr_raddr, (m_t == 1) ? m_addr : 12'h0);
            chk("alu_own", alu_own, m_t == 2);
            chk("alu_op_a", alu_op_a, (m_t == 2) ? m_src : 32'h0);
            chk("alu_op_b", alu_op_b, (m_t == 2) ? m_old : 32'h0);
            chk("alu_op", alu_op, (m_t == 2) ? m_op : 4'h0);
            chk("csr_we", csr_we, m_wr_issue && (m_t == 3));
            chk("csr_waddr", csr_waddr, (m_wr_issue && m_t == 3) ? m_addr : 12'h0);
            chk("csr_wdata", csr_wdata, (m_wr_issue && m_t == 3) ? m_new : 32'h0);
            chk("rsp_valid", rsp_valid, m_t >= m_rsp_t);
            chk("rsp_rdata", rsp_rdata, (m_t >= m_rsp_t) ? m_old : 32'h0);
            chk("rsp_rd_we", rsp_rd_we, (m_t >= m_rsp_t) && !m_rd_zero && !m_ro);
            chk("rsp_err", rsp_err_s, (m_t >= m_rsp_t) && m_ro);
            if (m_t >= m_rsp_t && rsp_ready) m_active = 1'b0;
            else m_t++;
        end
    end

    // ---------------- driver tasks ----------------
    int          r_re_cnt, r_re_cyc, r_we_cnt, r_we_cyc, r_op_cyc, r_rsp_cyc;
    logic [31:0] r_wd, r_rdata;
    logic [3:0]  r_op;
    logic        r_rdwe, r_err;

    // One request; cycle numbers are relative to the accept cycle (0).
    task automatic run_req(input logic [1:0] kind, input logic [11:0] addr,
                           input logic [31:0] src, input logic sz, input logic rz,
                           input int stall);
        int  stall_left;
        bit  done;
        stall_left = stall;
        done = 1'b0;
        r_re_cnt = 0; r_re_cyc = -1; r_we_cnt = 0; r_we_cyc = -1;
        r_op_cyc = -1; r_rsp_cyc = -1; r_wd = '0; r_rdata = '0;
        r_op = '0; r_rdwe = 1'b0; r_err = 1'b0;
        @(posedge clock); #1;
        req_valid = 1'b1; req_kind = kind; req_addr = addr; req_src = src;
        req_src_zero = sz; req_rd_zero = rz;
        @(negedge clock);
        @(posedge clock); #1;
        req_valid = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            if (k > 1) begin
                @(posedge clock); #1;
            end
            if (rsp_valid && stall_left > 0) begin
                rsp_ready = 1'b0;
                stall_left--;
            end else begin
                rsp_ready = 1'b1;
            end
            @(negedge clock);
            if (csr_re) begin r_re_cnt++; r_re_cyc = k; end
            if (alu_own) begin r_op = alu_op; r_op_cyc = k; end
            if (csr_we) begin r_we_cnt++; r_we_cyc = k; r_wd = csr_wdata; end
            if (rsp_valid && rsp_ready) begin
                r_rsp_cyc = k; r_rdata = rsp_rdata; r_rdwe = rsp_rd_we; r_err = rsp_err_s;
                done = 1'b1;
                break;
            end
        end
        rsp_ready = 1'b1;
        if (!done) chk("rsp_timeout", 0, 1);
    endtask

    // CSRRW whose WR cycle is hit by reset.
    task automatic run_reset_in_wr(input logic [11:0] addr, input logic [31:0] src);
        @(posedge clock); #1;
        req_valid = 1'b1; req_kind = 2'b00; req_addr = addr; req_src = src;
        req_src_zero = 1'b0; req_rd_zero = 1'b0;
        @(posedge clock); #1;   // cycle 1
        req_valid = 1'b0;
        @(posedge clock); #1;   // cycle 2
        @(posedge clock); #1;   // cycle 3 (write cycle)
        reset = 1'b1;
        @(negedge clock);
        chk("rst_wr_csr_we", csr_we, 0);
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        chk("rst_wr_req_ready", req_ready, 1);
        chk("rst_wr_rsp_valid", rsp_valid, 0);
        chk("rst_wr_csr_we_after", csr_we, 0);
    endtask

    // ---------------- directed tests ----------------
    initial begin
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk("reset_req_ready", req_ready, 1);
        chk("reset_rsp_valid", rsp_valid, 0);

        // 1: CSRRS 0x300, 0x8 | 0x80
        mem[12'h300] = 32'h0000_0008;
        run_req(2'b01, 12'h300, 32'h0000_0080, 1'b0, 1'b0, 0);
        chk("t1_re_cyc", r_re_cyc, 1);
        chk("t1_op", r_op, OP_OR);
        chk("t1_op_cyc", r_op_cyc, 2);
        chk("t1_we_cyc", r_we_cyc, 3);
        chk("t1_wdata", r_wd, 32'h0000_0088);
        chk("t1_rsp_cyc", r_rsp_cyc, 4);
        chk("t1_rdata", r_rdata, 32'h0000_0008);
        chk("t1_rd_we", r_rdwe, 1);

        // 2: CSRRC clears low nibble
        mem[12'h340] = 32'hFFFF_00FF;
        run_req(2'b10, 12'h340, 32'h0000_000F, 1'b0, 1'b0, 0);
        chk("t2_wdata", r_wd, 32'hFFFF_00F0);
        chk("t2_rdata", r_rdata, 32'hFFFF_00FF);
        chk("t2_op", r_op, OP_CLR);

        // 3: CSRRS with src_zero: no write, response one cycle earlier
        mem[12'h341] = 32'h0000_1234;
        run_req(2'b01, 12'h341, 32'h0, 1'b1, 1'b0, 0);
        chk("t3_we_cnt", r_we_cnt, 0);
        chk("t3_rsp_cyc", r_rsp_cyc, 3);
        chk("t3_rdata", r_rdata, 32'h0000_1234);

        // 4: CSRRW to x0: no read, old reported as 0
        mem[12'h305] = 32'h0000_0011;
        run_req(2'b00, 12'h305, 32'hDEAD_BEEF, 1'b0, 1'b1, 0);
        chk("t4_re_cnt", r_re_cnt, 0);
        chk("t4_wdata", r_wd, 32'hDEAD_BEEF);
        chk("t4_rd_we", r_rdwe, 0);
        chk("t4_rdata", r_rdata, 32'h0);
        chk("t4_op", r_op, OP_OPA);

        // 5: response back-pressure for 3 cycles
        run_req(2'b00, 12'h300, 32'h0000_0055, 1'b0, 1'b0, 3);
        chk("t5_rsp_cyc", r_rsp_cyc, 7);
        chk("t5_rdata", r_rdata, 32'h0000_0088);
        chk("t5_wdata", r_wd, 32'h0000_0055);

        // reserved kind 11 behaves as RS
        mem[12'h342] = 32'h0000_00F0;
        run_req(2'b11, 12'h342, 32'h0000_000F, 1'b0, 1'b0, 0);
        chk("rsv_op", r_op, OP_OR);
        chk("rsv_wdata", r_wd, 32'h0000_00FF);
        chk("rsv_rsp_cyc", r_rsp_cyc, 4);

        // CSRRC with src_zero: read only
        run_req(2'b10, 12'h342, 32'h0, 1'b1, 1'b0, 0);
        chk("rcz_we_cnt", r_we_cnt, 0);
        chk("rcz_rdata", r_rdata, 32'h0000_00FF);

        // 6: reset in the write cycle, then confirm the CSR kept its value
        mem[12'h343] = 32'h0000_0001;
        run_reset_in_wr(12'h343, 32'h0000_0099);
        run_req(2'b01, 12'h343, 32'h0, 1'b1, 1'b0, 0);
        chk("t6_rdata_unchanged", r_rdata, 32'h0000_0001);
        run_req(2'b01, 12'h300, 32'h0, 1'b1, 1'b0, 0);
        chk("t6_prev_write", r_rdata, 32'h0000_0055);

`ifdef FWRISC_CSR_RO_CHECK_EN
        mem[12'hC00] = 32'h0000_0042;
        run_req(2'b00, 12'hC00, 32'h0000_0007, 1'b0, 1'b0, 0);
        chk("ro_we_cnt", r_we_cnt, 0);
        chk("ro_err", r_err, 1);
        chk("ro_rd_we", r_rdwe, 0);
        chk("ro_rsp_cyc", r_rsp_cyc, 3);
        chk("ro_rdata", r_rdata, 32'h0000_0042);
        run_req(2'b01, 12'hC01, 32'h0, 1'b1, 1'b0, 0);
        chk("ro_read_err", r_err, 0);
        chk("ro_read_rd_we", r_rdwe, 1);
`endif

        repeat (2) @(negedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fwrisc_csr_rmw_seq.md
Name: fwrisc_csr_rmw_seq

Overview:
Multi-cycle sequencer for CSR instructions (CSRRW/CSRRS/CSRRC and their immediate forms).
- Reads the CSR and drives the shared fwrisc_alu to compute the new value.
- Writes the result back and returns the old value for rd.
- Sits between the decode/execute stage and the CSR file. It owns the ALU port while busy; the pipeline muxes the ALU inputs to this block whenever alu_own=1.

Parameters:
CSR_ADDR_W, 12, CSR address width
DATA_W, 32, data width; must match the ALU width

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
req_valid  in  1  CSR request valid
req_ready  out  1  block idle and able to accept a request
req_kind  in  2  00=RW, 01=RS, 10=RC, 11=reserved (treated as RS)
req_addr  in  CSR_ADDR_W  CSR address
req_src  in  DATA_W  rs1 value or zero-extended uimm
req_src_zero  in  1  rs1 index / uimm field is zero
req_rd_zero  in  1  rd index is zero
csr_re  out  1  CSR read strobe
csr_raddr  out  CSR_ADDR_W  CSR read address
csr_rdata  in  DATA_W  read data, valid the cycle after csr_re
csr_we  out  1  CSR write strobe
csr_waddr  out  CSR_ADDR_W  CSR write address
csr_wdata  out  DATA_W  CSR write data
alu_own  out  1  this block drives the ALU this cycle
alu_op_a  out  DATA_W  ALU operand a
alu_op_b  out  DATA_W  ALU operand b
alu_op  out  4  ALU opcode (shared OP_* encoding)
alu_out  in  DATA_W  ALU result (combinational)
rsp_valid  out  1  response valid
rsp_ready  in  1  response accepted
rsp_rdata  out  DATA_W  old CSR value for rd
rsp_rd_we  out  1  rd must be written (=!req_rd_zero)

Behaviour:
- Reset: state=IDLE. All strobes (csr_re, csr_we, alu_own, rsp_valid) =0. Data outputs =0. req_ready=1.
- Request accepted when req_valid && req_ready. The block latches kind, addr, src, src_zero and rd_zero. req_ready=1 only in IDLE.
- Write-suppress flag wr_en:
  - RW: wr_en=1.
  - RS/RC: wr_en = !req_src_zero.
- Read-suppress flag rd_en:
  - RW with rd_zero: rd_en=0. The old value is reported as 0 and csr_re is never asserted.
  - Otherwise rd_en=1.
- FSM states: IDLE -> RD -> EXE -> WR -> RSP -> IDLE.
  - RD: csr_re=rd_en, csr_raddr=latched addr.
  - EXE:
    - Capture old = rd_en ? csr_rdata : 0.
    - alu_own=1, alu_op_a=src, alu_op_b=csr_rdata (0 if !rd_en).
    - alu_op: RW -> OP_OPA; RS -> OP_OR; RC -> OP_CLR (op_b & ~op_a).
    - Register alu_out into wdata.
    - Next state: WR if wr_en, else RSP.
  - WR: csr_we=1 for exactly one cycle, csr_waddr=addr, csr_wdata=wdata.
  - RSP: rsp_valid=1, rsp_rdata=old, rsp_rd_we=!rd_zero. Held stable until rsp_ready. On rsp_valid && rsp_ready -> IDLE.
- Latency (rsp_ready tied 1): request accepted in cycle 0 gives rsp_valid in cycle 4 (write) or cycle 3 (write suppressed). The next request is accepted one cycle after the response handshake (cycle 5/4).
- No back-to-back acceptance in the response cycle.
- alu_own=0 outside EXE; ALU outputs drive 0 when not owned.
- Reset mid-operation aborts the sequence. No csr_we is issued after reset, even from WR.
- Reserved kind 11 behaves exactly as RS.

Optional Feature:
FWRISC_CSR_RO_CHECK_EN:
- Defined:
  - An added output rsp_err (1 bit) is present.
  - If addr[11:10]==2'b11 (read-only CSR space) and wr_en=1, the WR state is skipped: csr_we stays 0.
  - rsp_err=1 with the response; rsp_rd_we=0.
- Not defined: no rsp_err port and no address check; all writes are issued.

Decomposition:
- Shared package fwrisc_csr_pkg:
  - req_kind encoding: CSR_RW, CSR_RS, CSR_RC.
  - FSM state enum.
  - Read-only address-field constant.
- ALU opcodes come from the existing shared OP_* definitions; no local re-encoding.
- No sub-module. The FSM and datapath registers stay flat in one module.

Test Plan:
1. CSRRS, addr 0x300, CSR=0x0000_0008, src=0x0000_0080, rsp_ready=1 -> csr_re cycle 1, alu_op=OP_OR cycle 2, csr_we cycle 3 with wdata 0x0000_0088, rsp_valid cycle 4 with rdata 0x0000_0008.
2. CSRRC, CSR=0xFFFF_00FF, src=0x0000_000F -> wdata 0xFFFF_00F0, rdata 0xFFFF_00FF.
3. CSRRS with src_zero=1, CSR=0x1234 -> no csr_we, rsp_valid cycle 3, rdata 0x1234.
4. CSRRW with rd_zero=1, src=0xDEAD_BEEF -> csr_re never asserted, wdata 0xDEAD_BEEF, rsp_rd_we=0.
5. rsp_ready held 0 for 3 cycles -> rsp_valid/rdata stable, req_ready=0; accept on release, IDLE next cycle.
6. Reset asserted in the WR cycle -> csr_we=0 that cycle onward, all outputs at reset values, req_ready=1 the next cycle. With FWRISC_CSR_RO_CHECK_EN: CSRRW to 0xC00 -> no csr_we, rsp_err=1.
